// File: rtl/sram_sync_pkg.sv
// Shared types and helpers for the synchronous SRAM controller family.
//   state_t   : controller FSM states (ST_CLEAR, ST_IDLE)
//   lane_cnt  : number of byte lanes in a word
//   byte_par  : even-parity bit for one byte
package sram_sync_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic int lane_cnt(input int data_w);
    return data_w / 8;
  endfunction

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic byte_par(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Fixed-latency valid/data delay line with synchronous flush.
//   clk       : clock
//   flush     : synchronous clear of all valid bits and data
//   in_valid  : valid entering stage 0
//   in_data   : data entering stage 0
//   out_valid : valid leaving the last stage (STAGES cycles later)
//   out_data  : data of the last stage; holds its value between valids
module sram_rd_pipe #(
  parameter int STAGES = 1,
  parameter int W      = 16
) (
  input  logic         clk,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [STAGES-1:0]        vld_pipe;
  logic [STAGES-1:0][W-1:0] dat_pipe;

  // Data only advances alongside a valid bit, so the last stage keeps the
  // previous response until a new one arrives.
  always_ff @(posedge clk) begin
    if (flush) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= in_valid;
      if (in_valid) dat_pipe[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign out_valid = vld_pipe[STAGES-1];
  assign out_data  = dat_pipe[STAGES-1];

endmodule

// File: rtl/sram_sync_ctrl.sv
// Synchronous single-port SRAM with valid/ready request port, fixed-latency
// read response, byte-lane write enables and a post-reset clear sequencer.
// Optional macro SRAM_SYNC_PARITY_EN adds per-lane even parity and rsp_perr.
//   clk, rst   : clock, synchronous active-high reset
//   req_*      : request (valid/ready, we, addr, wdata, byte enables)
//   rsp_valid  : one-cycle pulse per accepted read, RD_LAT cycles later
//   rsp_rdata  : read data, held until the next rsp_valid
//   rsp_perr   : (parity build) lane parity mismatch, qualified by rsp_valid
//   busy       : clear sequence in progress
module sram_sync_ctrl
  import sram_sync_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int DEPTH        = 16,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int NL = lane_cnt(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AW-1:0]     req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NL-1:0]     req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
`ifdef SRAM_SYNC_PARITY_EN
  output logic              rsp_perr,
`endif
  output logic              busy
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
`ifdef SRAM_SYNC_PARITY_EN
  localparam int PW = DATA_W + 1;
`else
  localparam int PW = DATA_W;
`endif

  state_t            state, state_nxt;
  logic [AW-1:0]     clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef SRAM_SYNC_PARITY_EN
  logic [NL-1:0]     par_mem [DEPTH];
`endif

  logic              acc, addr_ok, wr_en, rd_en;
  logic [DATA_W-1:0] rd_word;
  logic              rd_perr;
  logic [PW-1:0]     pipe_in, pipe_out;

  assign acc     = req_valid & req_ready;
  assign addr_ok = {1'b0, req_addr} < DEPTH_W;
  assign wr_en   = acc & req_we & addr_ok;   // out-of-range writes are dropped
  assign rd_en   = acc & ~req_we;            // out-of-range reads still answer

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_CLEAR && clr_cnt == LAST) state_nxt = ST_IDLE;
  end

  // req_ready is masked by rst so nothing is accepted while reset is held,
  // including the CLEAR_ON_RST=0 case where the reset state is already IDLE.
  always_comb begin
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      ST_CLEAR: busy      = 1'b1;
      ST_IDLE:  req_ready = ~rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                                   clr_cnt <= '0;
    else if (state == ST_CLEAR && clr_cnt != LAST) clr_cnt <= clr_cnt + 1'b1;
  end

  // ---------------- storage ----------------
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
`ifdef SRAM_SYNC_PARITY_EN
      par_mem[clr_cnt] <= '0;
`endif
    end else if (wr_en) begin
      for (int i = 0; i < NL; i++) begin
        if (req_be[i]) begin
          mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef SRAM_SYNC_PARITY_EN
          par_mem[req_addr][i] <= byte_par(req_wdata[8*i +: 8]);
`endif
        end
      end
    end
  end

  // Read samples the array in the acceptance cycle; a write accepted the
  // cycle before has already landed.
  always_comb begin
    rd_word = '0;
    rd_perr = 1'b0;
    if (addr_ok) begin
      rd_word = mem[req_addr];
`ifdef SRAM_SYNC_PARITY_EN
      for (int i = 0; i < NL; i++)
        rd_perr = rd_perr | (byte_par(rd_word[8*i +: 8]) ^ par_mem[req_addr][i]);
`endif
    end
  end

  // ---------------- response pipe ----------------
`ifdef SRAM_SYNC_PARITY_EN
  assign pipe_in   = {rd_perr, rd_word};
  assign rsp_rdata = pipe_out[DATA_W-1:0];
  // Held pipe data would otherwise leave perr up after the valid pulse.
  assign rsp_perr  = rsp_valid & pipe_out[DATA_W];
`else
  assign pipe_in   = rd_word;
  assign rsp_rdata = pipe_out;
  logic unused_perr;
  assign unused_perr = rd_perr;
`endif

  sram_rd_pipe #(
    .STAGES (RD_LAT),
    .W      (PW)
  ) u_rd_pipe (
    .clk       (clk),
    .flush     (rst),
    .in_valid  (rd_en),
    .in_data   (pipe_in),
    .out_valid (rsp_valid),
    .out_data  (pipe_out)
  );

endmodule

// File: tb/tb_sram_sync_ctrl.sv
// Randomized self-checking bench for sram_sync_ctrl (DEPTH=12, RD_LAT=3).
module tb_sram_sync_ctrl;
  localparam int DW = 16, DEPTH = 12, RD_LAT = 3, AW = 4, NL = 2;

  logic          clk = 1'b0, rst = 1'b1;
  logic          req_valid = 1'b0, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NL-1:0] req_be = '0;
  logic          req_ready, rsp_valid, busy;
  logic [DW-1:0] rsp_rdata;
`ifdef SRAM_SYNC_PARITY_EN
  logic          rsp_perr;
`endif

  always #5 clk = ~clk;

  sram_sync_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(RD_LAT), .CLEAR_ON_RST(1)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
`ifdef SRAM_SYNC_PARITY_EN
    .rsp_perr(rsp_perr),
`endif
    .busy(busy)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
    logic          perr;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  logic [NL-1:0] model_par [DEPTH];
  logic [DW-1:0] last_data;
  int            cyc, n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: check outputs for this cycle, present the request,
  // update the reference model, then advance to the next falling edge.
  task automatic step(input logic v, input logic we, input int addr,
                      input logic [DW-1:0] wd, input logic [NL-1:0] be);
    bit            ev = 1'b0;
    logic [DW-1:0] ed;
    logic          ep = 1'b0;
    ed = last_data;
    chk("busy", 32'(busy), 32'(cyc < DEPTH));
    chk("req_ready", 32'(req_ready), 32'(cyc >= DEPTH));
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      ev = 1'b1; ed = exp_q[0].data; ep = exp_q[0].perr;
      last_data = ed;
      void'(exp_q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(ed));
`ifdef SRAM_SYNC_PARITY_EN
    chk("rsp_perr", 32'(rsp_perr), 32'(ep));
`endif
    req_valid = v; req_we = we; req_addr = addr[AW-1:0];
    req_wdata = wd; req_be = be;
    if (v && cyc >= DEPTH) begin
      if (we) begin
        if (addr < DEPTH)
          for (int i = 0; i < NL; i++)
            if (be[i]) begin
              model[addr][8*i +: 8] = wd[8*i +: 8];
              model_par[addr][i]    = ^wd[8*i +: 8];
            end
      end else begin
        rsp_t r;
        r.due = cyc + RD_LAT; r.data = '0; r.perr = 1'b0;
        if (addr < DEPTH) begin
          r.data = model[addr];
          for (int i = 0; i < NL; i++)
            if ((^r.data[8*i +: 8]) != model_par[addr][i]) r.perr = 1'b1;
        end
        exp_q.push_back(r);
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_valid = 1'b0;
    repeat (n) @(negedge clk);
    exp_q.delete();
    last_data = '0;
    for (int a = 0; a < DEPTH; a++) begin model[a] = '0; model_par[a] = '0; end
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic rand_steps(input int n);
    for (int k = 0; k < n; k++)
      step(($urandom_range(3, 0) != 0), 1'($urandom_range(1, 0)),
           int'($urandom_range(DEPTH + 3, 0)), DW'($urandom), NL'($urandom));
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    do_reset(2);
    // Requests offered during CLEAR must be ignored.
    for (int k = 0; k < DEPTH; k++) step(1'b1, 1'b1, k, 16'hDEAD, 2'b11);
    // Cleared array reads back as zero.
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, a, '0, '0);
    idle(RD_LAT);

    // Byte-lane merge: A5C3 then lane 0 <= 00 gives A500.
    step(1'b1, 1'b1, 3, 16'hA5C3, 2'b11);
    step(1'b1, 1'b1, 3, 16'hFF00, 2'b01);
    step(1'b1, 1'b0, 3, '0, '0);
    idle(RD_LAT - 1);
    chk("lane_merge_valid", 32'(rsp_valid), 32'd1);
    chk("lane_merge_data", 32'(rsp_rdata), 32'h0000A500);
    idle(1);

    // Back-to-back reads, responses in order on consecutive cycles.
    step(1'b1, 1'b1, 0, 16'h1111, 2'b11);
    step(1'b1, 1'b1, 1, 16'h2222, 2'b11);
    step(1'b1, 1'b1, 2, 16'h3333, 2'b11);
    step(1'b1, 1'b0, 0, '0, '0);
    step(1'b1, 1'b0, 1, '0, '0);
    step(1'b1, 1'b0, 2, '0, '0);
    idle(RD_LAT + 1);

    // Out-of-range write dropped, read returns zero; neighbour untouched.
    step(1'b1, 1'b1, 13, 16'hBEEF, 2'b11);
    step(1'b1, 1'b0, 13, '0, '0);
    step(1'b1, 1'b0, 1, '0, '0);
    idle(RD_LAT + 1);

    rand_steps(400);

    // Reset with two reads in flight: flushed, then CLEAR reruns.
    step(1'b1, 1'b0, 1, '0, '0);
    step(1'b1, 1'b0, 2, '0, '0);
    do_reset(1);
    idle(DEPTH + RD_LAT + 2);
    for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, a, '0, '0);
    idle(RD_LAT);

    rand_steps(300);
    idle(RD_LAT + 1);

`ifdef SRAM_SYNC_PARITY_EN
    step(1'b1, 1'b1, 5, 16'h1234, 2'b11);
    step(1'b1, 1'b1, 6, 16'h0F0F, 2'b11);
    dut.mem[5][0] = ~dut.mem[5][0];
    model[5][0]   = ~model[5][0];
    step(1'b1, 1'b0, 5, '0, '0);
    step(1'b1, 1'b0, 6, '0, '0);
    idle(RD_LAT - 2);
    chk("perr_flip", 32'(rsp_perr), 32'd1);
    idle(1);
    chk("perr_clean", 32'(rsp_perr), 32'd0);
    idle(2);
`endif

    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
